vec_issue_queue: RTL and testbench

- Upstream neighbour of the OVI bridge.
- Buffers vector instructions handed over by the core decode stage and presents them on the `core_issue_bus`, obeying `CORE_HALT` back-pressure.
- Tracks issued-but-incomplete instructions in order and returns `core_completed_bus` results to core writeback with their tag.
- Decouples decode from bridge stalls; supports a pipeline flush of not-yet-issued entries.

---
 rtl/vec_issue_queue_pkg.sv | 33 +++
 rtl/vec_issue_queue_if.sv | 32 +++
 rtl/viq_fifo.sv | 62 ++++++
 rtl/vec_issue_queue.sv | 143 ++++++++++++++
 tb/tb_vec_issue_queue.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/vec_issue_queue_pkg.sv
// Shared definitions for the vector issue queue: bridge bus structs, SEW codes, queue entry.
package vec_issue_queue_pkg;

  localparam int unsigned VIQ_VL_W  = 8;
  // Width of the tag field carried inside a queue entry; the top's TAG_W must match.
  localparam int unsigned VIQ_TAG_W = 3;

  // Element width codes carried on DEC_SEW / CORE_ISSUE.sew.
  localparam logic [2:0] SEW_E8  = 3'd0;
  localparam logic [2:0] SEW_E16 = 3'd1;
  localparam logic [2:0] SEW_E32 = 3'd2;
  localparam logic [2:0] SEW_E64 = 3'd3;

  typedef struct packed {
    logic                valid;
    logic [31:0]         instr;
    logic [VIQ_VL_W-1:0] vl;
    logic [2:0]          sew;
  } core_issue_bus;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } core_completed_bus;

  typedef struct packed {
    logic [31:0]          instr;
    logic [VIQ_VL_W-1:0]  vl;
    logic [2:0]           sew;
    logic [VIQ_TAG_W-1:0] tag;
  } viq_entry_t;

endpackage

// File: rtl/vec_issue_queue_if.sv
// Decode / bridge / writeback signal bundle of the vector issue queue.
// slave: the queue itself; master: the surrounding core and bridge.
interface vec_issue_queue_if #(
  parameter int unsigned TAG_W = vec_issue_queue_pkg::VIQ_TAG_W
);
  import vec_issue_queue_pkg::*;

  logic                DEC_VALID;
  logic [31:0]         DEC_INSTR;
  logic [VIQ_VL_W-1:0] DEC_VL;
  logic [2:0]          DEC_SEW;
  logic                DEC_READY;
  logic                FLUSH;
  core_issue_bus       CORE_ISSUE;
  logic                CORE_HALT;
  core_completed_bus   CORE_COMPLETED;
  logic                WB_VALID;
  logic [63:0]         WB_DATA;
  logic [TAG_W-1:0]    WB_TAG;
  logic                ERR_STRAY;

  modport slave (
    input  DEC_VALID, DEC_INSTR, DEC_VL, DEC_SEW, FLUSH, CORE_HALT, CORE_COMPLETED,
    output DEC_READY, CORE_ISSUE, WB_VALID, WB_DATA, WB_TAG, ERR_STRAY
  );

  modport master (
    output DEC_VALID, DEC_INSTR, DEC_VL, DEC_SEW, FLUSH, CORE_HALT, CORE_COMPLETED,
    input  DEC_READY, CORE_ISSUE, WB_VALID, WB_DATA, WB_TAG, ERR_STRAY
  );

endinterface

// File: rtl/viq_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count. Pointers carry one extra
// wrap bit so full and empty are told apart by the MSB. A flush in the same cycle as a
// pop lets the pop complete and discards everything behind it.
module viq_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned Depth = 4,
  localparam int unsigned IdxW = $clog2(Depth),
  localparam int unsigned PtrW = IdxW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  T                wdata_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output T                rdata_o,
  output logic [PtrW-1:0] count_o,
  output logic            full_o
);

  T                mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  // Occupancy flags and pointer next-state.
  always_comb begin
    empty   = (wptr_q == rptr_q);
    full_o  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) && (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
    count_o = wptr_q - rptr_q;
    rdata_o = mem_q[rptr_q[IdxW-1:0]];
    do_pop  = pop_i && !empty;
    do_push = push_i && !full_o && !flush_i;
    rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
    if (flush_i) begin
      wptr_d = rptr_d;
    end else begin
      wptr_d = do_push ? wptr_q + PtrW'(1) : wptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[IdxW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/vec_issue_queue.sv
// Vector issue queue: buffers decoded vector instructions, issues them to the OVI bridge
// under CORE_HALT back-pressure, tracks issued tags in order and returns completions to
// writeback with their tag.
// Optional feature: define VIQ_BYPASS_EN for a zero-cycle decode->issue path when empty.
module vec_issue_queue
  import vec_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned TAG_W        = VIQ_TAG_W
) (
  input logic              CLK,
  input logic              RST,
  vec_issue_queue_if.slave bus
);

  localparam int unsigned QCntW   = $clog2(DEPTH) + 1;
  localparam int unsigned InfCntW = $clog2(MAX_INFLIGHT) + 1;

  viq_entry_t           dec_entry;
  viq_entry_t           head;
  logic [QCntW-1:0]     q_count;
  logic                 q_full;
  logic [InfCntW-1:0]   inf_count;
  logic                 inf_full;
  logic [TAG_W-1:0]     inf_head;
  logic [TAG_W-1:0]     inf_tag_in;
  logic                 q_nonempty;
  logic                 inf_nonempty;
  logic                 dec_ready;
  logic                 dec_fire;
  logic                 bypass;
  logic                 issue_fire;
  logic                 q_push;
  logic                 q_pop;
  logic                 inf_pop;
  core_issue_bus        issue;

  logic [TAG_W-1:0]     tag_cnt_q, tag_cnt_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [63:0]          wb_data_q, wb_data_d;
  logic [TAG_W-1:0]     wb_tag_q, wb_tag_d;
  logic                 err_q, err_d;

  // Handshake, issue selection and FIFO control.
  always_comb begin
    q_nonempty   = (q_count != '0);
    inf_nonempty = (inf_count != '0);
    dec_ready    = !RST && !bus.FLUSH && !q_full;
    dec_fire     = bus.DEC_VALID && dec_ready;

    dec_entry.instr = bus.DEC_INSTR;
    dec_entry.vl    = bus.DEC_VL;
    dec_entry.sew   = bus.DEC_SEW;
    dec_entry.tag   = VIQ_TAG_W'(tag_cnt_q);

    issue.valid = !RST && q_nonempty && !inf_full;
    issue.instr = head.instr;
    issue.vl    = head.vl;
    issue.sew   = head.sew;
`ifdef VIQ_BYPASS_EN
    bypass = !RST && !q_nonempty && bus.DEC_VALID && !inf_full && !bus.FLUSH;
    if (bypass) begin
      issue.valid = 1'b1;
      issue.instr = bus.DEC_INSTR;
      issue.vl    = bus.DEC_VL;
      issue.sew   = bus.DEC_SEW;
    end
`else
    bypass = 1'b0;
`endif
    issue_fire = issue.valid && !bus.CORE_HALT;
    // A bypassed instruction that issues at once never touches the FIFO.
    q_push     = dec_fire && !(bypass && issue_fire);
    q_pop      = issue_fire && !bypass;
    inf_tag_in = bypass ? tag_cnt_q : TAG_W'(head.tag);
    inf_pop    = !RST && bus.CORE_COMPLETED.valid && inf_nonempty;
  end

  // Next-state for tag counter, writeback registers and the sticky stray flag.
  always_comb begin
    tag_cnt_d  = dec_fire ? tag_cnt_q + TAG_W'(1) : tag_cnt_q;
    wb_valid_d = inf_pop;
    wb_data_d  = inf_pop ? bus.CORE_COMPLETED.data : wb_data_q;
    wb_tag_d   = inf_pop ? inf_head : wb_tag_q;
    err_d      = err_q || (bus.CORE_COMPLETED.valid && !inf_nonempty);
  end

  // State registers; reset discards everything, FLUSH never reaches these.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_cnt_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      tag_cnt_q  <= tag_cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_tag_q   <= wb_tag_d;
      err_q      <= err_d;
    end
  end

  viq_fifo #(
    .T     (viq_entry_t),
    .Depth (DEPTH)
  ) u_instr_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (q_push),
    .wdata_i (dec_entry),
    .pop_i   (q_pop),
    .flush_i (bus.FLUSH),
    .rdata_o (head),
    .count_o (q_count),
    .full_o  (q_full)
  );

  viq_fifo #(
    .T     (logic [TAG_W-1:0]),
    .Depth (MAX_INFLIGHT)
  ) u_inflight_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (issue_fire),
    .wdata_i (inf_tag_in),
    .pop_i   (inf_pop),
    .flush_i (1'b0),
    .rdata_o (inf_head),
    .count_o (inf_count),
    .full_o  (inf_full)
  );

  assign bus.DEC_READY  = dec_ready;
  assign bus.CORE_ISSUE = issue;
  assign bus.WB_VALID   = wb_valid_q;
  assign bus.WB_DATA    = wb_data_q;
  assign bus.WB_TAG     = wb_tag_q;
  assign bus.ERR_STRAY  = err_q;

endmodule

// File: tb/tb_vec_issue_queue.sv
// Directed bench for vec_issue_queue with a queue-based scoreboard of expected issues,
// in-flight tags and writebacks.
module tb_vec_issue_queue;
  import vec_issue_queue_pkg::*;

  localparam int unsigned Depth  = 4;
  localparam int unsigned MaxInf = 4;
  localparam int unsigned TagW   = 3;

  typedef struct {
    logic [31:0]         instr;
    logic [VIQ_VL_W-1:0] vl;
    logic [2:0]          sew;
    logic [TagW-1:0]     tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vec_issue_queue_if #(.TAG_W(TagW)) bus ();

  vec_issue_queue #(
    .DEPTH        (Depth),
    .MAX_INFLIGHT (MaxInf),
    .TAG_W        (TagW)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t            m_q[$];
  logic [TagW-1:0] m_inf[$];
  logic [TagW-1:0] m_tag = '0;
  logic            m_err = 1'b0;
  logic            m_wbv = 1'b0;
  logic [63:0]     m_wbd = '0;
  logic [TagW-1:0] m_wbt = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one cycle against the scoreboard, advance the model, then cross the clock edge.
  task automatic cycle();
    logic exp_rdy, exp_iv, byp, fire, acc, cmp;
    exp_t e;
    #1;
    chk("wb_valid", 64'(bus.WB_VALID), 64'(m_wbv));
    chk("wb_data", bus.WB_DATA, m_wbd);
    chk("wb_tag", 64'(bus.WB_TAG), 64'(m_wbt));
    chk("err_stray", 64'(bus.ERR_STRAY), 64'(m_err));
    exp_rdy = !rst && !bus.FLUSH && (m_q.size() < Depth);
    byp = 1'b0;
`ifdef VIQ_BYPASS_EN
    byp = !rst && (m_q.size() == 0) && bus.DEC_VALID && (m_inf.size() < MaxInf) && !bus.FLUSH;
`endif
    exp_iv = (!rst && (m_q.size() > 0) && (m_inf.size() < MaxInf)) || byp;
    chk("dec_ready", 64'(bus.DEC_READY), 64'(exp_rdy));
    chk("issue_valid", 64'(bus.CORE_ISSUE.valid), 64'(exp_iv));
    if (exp_iv) begin
      if (byp) e = '{instr: bus.DEC_INSTR, vl: bus.DEC_VL, sew: bus.DEC_SEW, tag: m_tag};
      else     e = m_q[0];
      chk("issue_instr", 64'(bus.CORE_ISSUE.instr), 64'(e.instr));
      chk("issue_vl", 64'(bus.CORE_ISSUE.vl), 64'(e.vl));
      chk("issue_sew", 64'(bus.CORE_ISSUE.sew), 64'(e.sew));
    end
    fire = exp_iv && !bus.CORE_HALT;
    acc  = bus.DEC_VALID && exp_rdy;
    cmp  = !rst && bus.CORE_COMPLETED.valid && (m_inf.size() > 0);
    if (rst) begin
      m_q.delete();
      m_inf.delete();
      m_tag = '0;
      m_err = 1'b0;
      m_wbv = 1'b0;
      m_wbd = '0;
      m_wbt = '0;
    end else begin
      if (cmp) begin
        m_wbv = 1'b1;
        m_wbd = bus.CORE_COMPLETED.data;
        m_wbt = m_inf.pop_front();
      end else begin
        m_wbv = 1'b0;
        if (bus.CORE_COMPLETED.valid) m_err = 1'b1;
      end
      if (fire) begin
        if (byp) begin
          m_inf.push_back(m_tag);
        end else begin
          m_inf.push_back(m_q[0].tag);
          void'(m_q.pop_front());
        end
      end
      if (bus.FLUSH) m_q.delete();
      if (acc) begin
        if (!(byp && fire)) begin
          m_q.push_back('{instr: bus.DEC_INSTR, vl: bus.DEC_VL, sew: bus.DEC_SEW, tag: m_tag});
        end
        m_tag = m_tag + TagW'(1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic dv, input logic [31:0] ins, input logic [7:0] vl,
                      input logic [2:0] sew, input logic fl, input logic hl,
                      input logic ccv, input logic [63:0] ccd);
    bus.DEC_VALID      = dv;
    bus.DEC_INSTR      = ins;
    bus.DEC_VL         = vl;
    bus.DEC_SEW        = sew;
    bus.FLUSH          = fl;
    bus.CORE_HALT      = hl;
    bus.CORE_COMPLETED = '{valid: ccv, data: ccd};
    cycle();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 8'h0, 3'h0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 8'h0, 3'h0, 1'b0, 1'b0, 1'(m_inf.size() > 0), 64'hCAFE_0000 + 64'(i));
    end
  endtask

  initial begin
    bus.DEC_VALID      = 1'b0;
    bus.DEC_INSTR      = '0;
    bus.DEC_VL         = '0;
    bus.DEC_SEW        = '0;
    bus.FLUSH          = 1'b0;
    bus.CORE_HALT      = 1'b0;
    bus.CORE_COMPLETED = '{valid: 1'b0, data: 64'h0};
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    idle();

    // Back-to-back: three enqueues, then three completions.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hA000_0000 + 32'(i), 8'(4 + i), 3'(i), 1'b0, 1'b0, 1'b0, 64'h0);
    end
    idle();
    idle();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 8'h0, 3'h0, 1'b0, 1'b0, 1'b1, 64'hD000_0000_0000_0000 + 64'(i));
    end
    idle();

    // Full: halted, five offers, four accepted; then release and fill in-flight.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hB000_0000 + 32'(i), 8'(16 + i), 3'(i % 4), 1'b0, 1'b1, 1'b0, 64'h0);
    end
    step(1'b1, 32'hB100_0000, 8'd30, SEW_E64, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 32'hB100_0001, 8'd31, SEW_E8, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 32'hB100_0002, 8'd32, SEW_E16, 1'b0, 1'b0, 1'b0, 64'h0);
    idle();
    idle();
    step(1'b0, 32'h0, 8'h0, 3'h0, 1'b0, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
    step(1'b0, 32'h0, 8'h0, 3'h0, 1'b0, 1'b0, 1'b1, 64'h5555_6666_7777_8888);
    drain();

    // Flush in the same cycle as a pop.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'hC000_0000 + 32'(i), 8'(40 + i), SEW_E32, 1'b0, 1'b1, 1'b0, 64'h0);
    end
    step(1'b0, 32'h0, 8'h0, 3'h0, 1'b1, 1'b0, 1'b0, 64'h0);
    idle();
    step(1'b0, 32'h0, 8'h0, 3'h0, 1'b0, 1'b0, 1'b1, 64'hF1F1_F1F1_0000_0001);
    idle();
    idle();

    // Stray: reset with two in flight, then a completion.
    step(1'b1, 32'hD000_0000, 8'd9, SEW_E8, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b1, 32'hD000_0001, 8'd10, SEW_E16, 1'b0, 1'b0, 1'b0, 64'h0);
    idle();
    idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    step(1'b0, 32'h0, 8'h0, 3'h0, 1'b0, 1'b0, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0);
    repeat (3) idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    idle();

    // Wrap: sustained enqueue/issue/complete; tags wrap 7 -> 0.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'hE000_0000 + 32'(i), 8'(i), 3'(i % 4), 1'b0, 1'b0, 1'(i >= 2),
           64'h0123_0000_0000_0000 + 64'(i));
    end
    drain();

    chk("model_queue_empty", 64'(m_q.size()), 64'd0);
    chk("model_inflight_empty", 64'(m_inf.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
